// File: rtl/mux4way_rr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : mux4way_rr
//  Purpose  : Merges four valid/ready word streams (a, b, c, d) onto one
//             registered output stream. Each output word carries a 2-bit
//             source tag (00=a, 01=b, 10=c, 11=d). Arbitration is round-robin
//             by default.
//  Options  : MUX4WAY_FIXED_PRIO_EN
//             When defined, arbitration becomes fixed priority a>b>c>d and
//             the round-robin pointer is removed. Ports, latency and
//             handshake are the same in both builds.
//  Revision : 1.0  initial release
// ============================================================================
module mux4way_rr #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   // source a
   input  logic [WIDTH-1:0] in_a,
   input  logic             a_valid,
   output logic             a_ready,
   // source b
   input  logic [WIDTH-1:0] in_b,
   input  logic             b_valid,
   output logic             b_ready,
   // source c
   input  logic [WIDTH-1:0] in_c,
   input  logic             c_valid,
   output logic             c_ready,
   // source d
   input  logic [WIDTH-1:0] in_d,
   input  logic             d_valid,
   output logic             d_ready,
   // merged output stream
   output logic [WIDTH-1:0] out,
   output logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int c_num_src = 4;

   // ------------------------------------------------------------------------
   // Source bundling: index 0..3 corresponds to a..d, which is also the tag
   // value written to sel.
   // ------------------------------------------------------------------------
   logic [c_num_src-1:0] w_valid;
   logic [WIDTH-1:0]     w_data [c_num_src];
   logic [c_num_src-1:0] w_ready;

   assign w_valid   = {d_valid, c_valid, b_valid, a_valid};
   assign w_data[0] = in_a;
   assign w_data[1] = in_b;
   assign w_data[2] = in_c;
   assign w_data[3] = in_d;

   assign a_ready = w_ready[0];
   assign b_ready = w_ready[1];
   assign c_ready = w_ready[2];
   assign d_ready = w_ready[3];

   // ------------------------------------------------------------------------
   // Output stage registers
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] r_out;
   logic [1:0]       r_sel;
   logic             r_out_valid;

   assign out       = r_out;
   assign sel       = r_sel;
   assign out_valid = r_out_valid;

   // The stage can take a new word when it is empty or its current word is
   // leaving this cycle (drain and refill in the same edge, no bubble).
   logic w_load;
   assign w_load = ~r_out_valid | out_ready;

   // ------------------------------------------------------------------------
   // Search start point. Round-robin keeps a pointer to the source after the
   // last winner; fixed priority always starts at a.
   // ------------------------------------------------------------------------
   logic [1:0] w_start;

`ifdef MUX4WAY_FIXED_PRIO_EN
   assign w_start = 2'b00;
`else
   logic [1:0] r_ptr;
   assign w_start = r_ptr;
`endif

   // ------------------------------------------------------------------------
   // Grant search
   // ------------------------------------------------------------------------
   logic [1:0] w_gnt;
   logic       w_gnt_vld;

   // Pick the first valid source at or after w_start, wrapping 3 -> 0.
   // The loop walks offsets from far to near so the nearest valid source is
   // the last assignment and therefore wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = w_start;
      for (int i = c_num_src - 1; i >= 0; i--) begin
         if (w_valid[w_start + 2'(i)]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_start + 2'(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Ready generation. Readies are forced low while reset is asserted so a
   // source that happens to be selected during reset never sees a transfer.
   // ------------------------------------------------------------------------
   logic w_take;
   assign w_take = rst_n & w_load & w_gnt_vld;

   for (genvar gi = 0; gi < c_num_src; gi++) begin : g_ready
      localparam logic [1:0] c_idx = 2'(gi);
      assign w_ready[gi] = w_take & (w_gnt == c_idx);
   end

   // ------------------------------------------------------------------------
   // Output stage: capture the winning word and its tag, or empty the stage
   // when it drains with nothing to replace it. Holds under backpressure.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out       <= '0;
         r_sel       <= 2'b00;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         if (w_gnt_vld) begin
            r_out       <= w_data[w_gnt];
            r_sel       <= w_gnt;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifndef MUX4WAY_FIXED_PRIO_EN
   // Advance the round-robin pointer past each winner; it only moves when a
   // word is actually accepted, so waiting sources keep their position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 2'b00;
      end else if (w_load && w_gnt_vld) begin
         r_ptr <= w_gnt + 2'b01;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux4way_rr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mux4way_rr
//  Purpose  : Self-checking bench for mux4way_rr. A reference model predicts
//             each grant at every clock and queues the expected word; a
//             separate monitor pops and compares on every output handshake.
//             Build with +define+MUX4WAY_FIXED_PRIO_EN for the fixed build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux4way_rr;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] data_v [4];
   logic [3:0]       valid_v;
   logic             a_ready, b_ready, c_ready, d_ready;
   logic [3:0]       rdy;
   logic [WIDTH-1:0] out;
   logic [1:0]       sel;
   logic             out_valid;
   logic             out_ready;

   assign rdy = {d_ready, c_ready, b_ready, a_ready};

   mux4way_rr #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_a      (data_v[0]),
      .a_valid   (valid_v[0]),
      .a_ready   (a_ready),
      .in_b      (data_v[1]),
      .b_valid   (valid_v[1]),
      .b_ready   (b_ready),
      .in_c      (data_v[2]),
      .c_valid   (valid_v[2]),
      .c_ready   (c_ready),
      .in_d      (data_v[3]),
      .d_valid   (valid_v[3]),
      .d_ready   (d_ready),
      .out       (out),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

`ifdef MUX4WAY_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Reference model and scoreboard
   // ---------------------------------------------------------------------
   typedef struct {
      logic [1:0]       src;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t exp_q [$];
   bit   m_full = 1'b0;   // output stage occupied
   int   m_next = 0;      // first source to look at next time

   // Predict the transfer at the coming rising edge from sampled inputs.
   always @(negedge clk) begin
      int   win;
      int   s;
      bit   load;
      logic [3:0] exp_rdy;
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         m_full = 1'b0;
         m_next = 0;
      end else begin
         load = !m_full || out_ready;
         win  = -1;
         if (load) begin
            for (int k = 0; k < 4; k++) begin
               s = (m_next + k) % 4;
               if (win < 0 && valid_v[s]) win = s;
            end
         end
         exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
         chk("ready", {28'd0, rdy}, {28'd0, exp_rdy});
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
         if (win >= 0) begin
            e.src  = 2'(win);
            e.data = data_v[win];
            exp_q.push_back(e);
            m_full = 1'b1;
            m_next = FIXED ? 0 : (win + 1) % 4;
         end else if (load) begin
            m_full = 1'b0;
         end
      end
   end

   // Monitor: compare every word the consumer takes.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", {16'd0, out}, {16'd0, e.data});
            chk("out_sel", {30'd0, sel}, {30'd0, e.src});
         end
      end
   end

   // ---------------------------------------------------------------------
   // Source driver
   // ---------------------------------------------------------------------
   int         mode;   // 0: drop after accept, 1: keep presenting, 2: random
   logic [3:0] acc;

   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < 4; i++) acc[i] = valid_v[i] & rdy[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (mode == 0) begin
            if (acc[i]) valid_v[i] = 1'b0;
         end else if (mode == 2) begin
            if (acc[i] || !valid_v[i]) begin
               if ($urandom_range(1) == 1) begin
                  valid_v[i] = 1'b1;
                  data_v[i]  = 16'($urandom);
               end else begin
                  valid_v[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic all_valid();
      for (int i = 0; i < 4; i++) begin
         valid_v[i] = 1'b1;
         data_v[i]  = 16'(i + 1);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      mode      = 1;
      acc       = 4'b0000;
      all_valid();

      // Reset with every source requesting
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {28'd0, rdy}, 32'd0);
      chk("rst_out", {16'd0, out}, 32'd0);
      chk("rst_sel", {30'd0, sel}, 32'd0);
      rst_n = 1'b1;

      // Round-robin with all sources valid; first grant after reset is a
      for (int k = 0; k < 8; k++) begin
         cycle();
         chk("rr_sel", {30'd0, sel}, FIXED ? 32'd0 : 32'(k % 4));
         chk("rr_data", {16'd0, out}, FIXED ? 32'd1 : 32'(k % 4 + 1));
      end

      // Single source c
      mode    = 0;
      valid_v = 4'b0100;
      data_v[2] = 16'h1234;
      cycle();
      chk("single_c_acc", {28'd0, acc}, 32'h4);
      chk("single_c_out", {16'd0, out}, 32'h1234);
      chk("single_c_sel", {30'd0, sel}, 32'd2);
      chk("single_c_vld", {31'd0, out_valid}, 32'd1);

      // Backpressure with BEEF held and b waiting
      valid_v[0] = 1'b1;
      data_v[0]  = 16'hBEEF;
      cycle();
      chk("bp_load", {16'd0, out}, 32'hBEEF);
      out_ready  = 1'b0;
      valid_v[1] = 1'b1;
      data_v[1]  = 16'h0B0B;
      repeat (5) begin
         @(negedge clk);
         chk("bp_b_ready", {31'd0, b_ready}, 32'd0);
         chk("bp_out", {16'd0, out}, 32'hBEEF);
         chk("bp_sel", {30'd0, sel}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_b_acc", {31'd0, acc[1]}, 32'd1);
      chk("bp_b_out", {16'd0, out}, 32'h0B0B);
      chk("bp_b_sel", {30'd0, sel}, 32'd1);

      // Drain to empty: tag and word stay put
      cycle();
      chk("drain_vld", {31'd0, out_valid}, 32'd0);
      chk("drain_out", {16'd0, out}, 32'h0B0B);
      chk("drain_sel", {30'd0, sel}, 32'd1);

      // Asynchronous reset in the middle of a round-robin stream
      mode = 1;
      all_valid();
      repeat (3) cycle();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_ready", {28'd0, rdy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("arst_restart_sel", {30'd0, sel}, 32'd0);
      chk("arst_restart_out", {16'd0, out}, 32'd1);

      // Randomised traffic with random backpressure
      mode = 2;
      repeat (400) begin
         out_ready = ($urandom_range(3) != 0);
         cycle();
      end

      // Drain everything still in flight
      mode      = 0;
      valid_v   = 4'b0000;
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("final_out_valid", {31'd0, out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
